// File: rtl/reg_bank_8x32_scan_pkg.sv
// reg_bank_8x32_scan_pkg: shared types and sizes for the scanned register bank
package reg_bank_8x32_scan_pkg;
    localparam int NUM_ENTRIES   = 8;
    localparam int SEL_WIDTH     = 3;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;
endpackage

// File: rtl/reg_bank_8x32_scan_next_set_bit_8.sv
// next_set_bit_8: lowest set mask bit above (or at, for the first pick) the current index
module next_set_bit_8
    import reg_bank_8x32_scan_pkg::*;
(
    input  logic [NUM_ENTRIES-1:0] i_mask,
    input  logic [SEL_WIDTH-1:0]   i_cur,
    input  logic                   i_include_current,
    output logic [SEL_WIDTH-1:0]   o_next,
    output logic                   o_found
);
    // Walk downward so the lowest qualifying index is the last one written
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (i_mask[i] && (i > int'(i_cur) || (i_include_current && i == int'(i_cur)))) begin
                o_next  = SEL_WIDTH'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/reg_bank_8x32_scan.sv
// reg_bank_8x32_scan: 8x32 register bank with a masked, handshaked Select sequencer
module reg_bank_8x32_scan
    import reg_bank_8x32_scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wr_en,
    input  logic [SEL_WIDTH-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_start,
    input  logic [NUM_ENTRIES-1:0] i_mask,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_out0,
    output logic [WIDTH-1:0]       o_out1,
    output logic [WIDTH-1:0]       o_out2,
    output logic [WIDTH-1:0]       o_out3,
    output logic [WIDTH-1:0]       o_out4,
    output logic [WIDTH-1:0]       o_out5,
    output logic [WIDTH-1:0]       o_out6,
    output logic [WIDTH-1:0]       o_out7,
    output logic [SEL_WIDTH-1:0]   o_select,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic                   o_done
);
    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_regs [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_mask;
    logic [NUM_ENTRIES-1:0] w_nsb_mask;
    logic [SEL_WIDTH-1:0]   r_select;
    logic [SEL_WIDTH-1:0]   w_select_next;
    logic [SEL_WIDTH-1:0]   w_nsb_cur;
    logic [SEL_WIDTH-1:0]   w_nsb_next;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_idle;
    logic                   w_nsb_found;
    logic                   w_advance;

    // In IDLE the search runs on the incoming mask from index 0; in SCAN on the latched mask past Select
    assign w_idle     = r_state == ST_IDLE;
    assign w_nsb_mask = w_idle ? i_mask : r_mask;
    assign w_nsb_cur  = w_idle ? SEL_WIDTH'(0) : r_select;

    next_set_bit_8 u_next_set_bit (
        .i_mask           (w_nsb_mask),
        .i_cur            (w_nsb_cur),
        .i_include_current(w_idle),
        .o_next           (w_nsb_next),
        .o_found          (w_nsb_found)
    );

    // Advance on an accepted Start or a handshake; run out of set bits means DONE
    always_comb begin
        w_advance     = (w_idle && i_start) || (r_state == ST_SCAN && i_ready);
        w_state_next  = w_advance ? (w_nsb_found ? ST_SCAN : ST_DONE) : (r_state == ST_DONE ? ST_IDLE : r_state);
        w_select_next = (w_advance && w_nsb_found) ? w_nsb_next : r_select;
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Select, latched mask and status flags are registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_select <= '0;
            r_mask   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_select <= w_select_next;
            if (w_idle && i_start) r_mask <= i_mask;
            r_valid  <= w_state_next == ST_SCAN;
            r_busy   <= w_state_next != ST_IDLE;
            r_done   <= w_state_next == ST_DONE;
        end
    end

    // Write port, independent of the sequencer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) r_regs[i] <= '0;
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_out0   = r_regs[0];
    assign o_out1   = r_regs[1];
    assign o_out2   = r_regs[2];
    assign o_out3   = r_regs[3];
    assign o_out4   = r_regs[4];
    assign o_out5   = r_regs[5];
    assign o_out6   = r_regs[6];
    assign o_out7   = r_regs[7];
    assign o_select = r_select;
    assign o_valid  = r_valid;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
endmodule

// File: tb/tb_reg_bank_8x32_scan.sv
// tb_reg_bank_8x32_scan: directed stimulus, queue-based reference model, per-cycle compare
module tb_reg_bank_8x32_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [7:0]  mask;
    logic        ready;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [2:0]  sel;
    logic        valid, busy, done;
    logic [31:0] outs [8];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [8];
    int          m_q [$];
    logic [2:0]  m_sel;
    logic        m_done;
    logic        m_ok = 1'b0;

    always #5 clk = ~clk;

    reg_bank_8x32_scan dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wr_en  (wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_start  (start),
        .i_mask   (mask),
        .i_ready  (ready),
        .o_out0   (out0),
        .o_out1   (out1),
        .o_out2   (out2),
        .o_out3   (out3),
        .o_out4   (out4),
        .o_out5   (out5),
        .o_out6   (out6),
        .o_out7   (out7),
        .o_select (sel),
        .o_valid  (valid),
        .o_busy   (busy),
        .o_done   (done)
    );

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign outs[4] = out4;
    assign outs[5] = out5;
    assign outs[6] = out6;
    assign outs[7] = out7;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a scan is the ascending list of set mask bits, consumed one per handshake
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_mem[i] = '0;
            m_q.delete();
            m_sel  = '0;
            m_done = 1'b0;
            m_ok   = 1'b1;
        end else begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_q.size() != 0) begin
                if (ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                    else m_sel = 3'(m_q[0]);
                end
            end else if (start) begin
                for (int i = 0; i < 8; i++) if (mask[i]) m_q.push_back(i);
                if (m_q.size() == 0) m_done = 1'b1;
                else m_sel = 3'(m_q[0]);
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    // Every cycle, mid-period, all outputs against the model
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_select", 32'(sel), 32'(m_sel));
            chk("m_valid", 32'(valid), 32'(m_q.size() != 0));
            chk("m_busy", 32'(busy), 32'(m_q.size() != 0 || m_done));
            chk("m_done", 32'(done), 32'(m_done));
            for (int i = 0; i < 8; i++) chk($sformatf("m_out%0d", i), outs[i], m_mem[i]);
        end
    end

    initial begin
        int hs_sel [$];
        int last_hs;
        int done_at;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; mask = '0; ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("rst_select", 32'(sel), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), outs[i], 0);

        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 1'b0;
        chk("wr_out5", out5, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 32'h11111111 * i;
            step();
        end
        wr_en = 1'b0;

        mask = 8'hFF; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("full_select", 32'(sel), c);
            chk("full_valid", 32'(valid), 1);
            chk("full_done_early", 32'(done), 0);
            chk("full_mux", outs[sel], 32'h11111111 * c);
            step();
        end
        chk("full_done_c9", 32'(done), 1);
        chk("full_valid_c9", 32'(valid), 0);
        step();
        chk("full_done_once", 32'(done), 0);
        chk("full_idle_busy", 32'(busy), 0);

        mask = 8'h92; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        last_hs = -1; done_at = -1;
        for (int c = 1; c < 20 && done_at < 0; c++) begin
            ready = (c % 2) == 1;
            if (done) done_at = c;
            if (valid && ready) begin
                hs_sel.push_back(int'(sel));
                last_hs = c;
            end
            step();
        end
        ready = 1'b0;
        chk("sparse_count", 32'(hs_sel.size()), 3);
        if (hs_sel.size() == 3) begin
            chk("sparse_sel0", 32'(hs_sel[0]), 1);
            chk("sparse_sel1", 32'(hs_sel[1]), 4);
            chk("sparse_sel2", 32'(hs_sel[2]), 7);
        end
        chk("sparse_done_cycle", 32'(done_at), 6);
        chk("sparse_done_gap", 32'(done_at - last_hs), 1);
        step();

        mask = 8'h00; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_valid", 32'(valid), 0);
        step();
        chk("zero_done_after", 32'(done), 0);
        chk("zero_valid_after", 32'(valid), 0);

        mask = 8'h05; start = 1'b1; ready = 1'b0;
        step();
        mask = 8'hF0;
        chk("ign_sel_c1", 32'(sel), 0);
        step();
        ready = 1'b1;
        chk("ign_sel_c2", 32'(sel), 0);
        step();
        start = 1'b0;
        chk("ign_sel_c3", 32'(sel), 2);
        chk("ign_valid_c3", 32'(valid), 1);
        step();
        chk("ign_done_c4", 32'(done), 1);
        step();
        chk("ign_idle", 32'(busy), 0);

        mask = 8'h08; start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0;
        ready = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hA5A5A5A5;
        chk("wh_sel", 32'(sel), 3);
        chk("wh_old", outs[sel], 32'h33333333);
        step();
        wr_en = 1'b0; ready = 1'b0;
        chk("wh_new", out3, 32'hA5A5A5A5);
        chk("wh_done", 32'(done), 1);
        step();

        mask = 8'hFF; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("mid_sel", 32'(sel), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_select", 32'(sel), 0);
        chk("mr_valid", 32'(valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("mr_out%0d", i), outs[i], 0);
        step();
        chk("mr_no_done", 32'(done), 0);
        chk("mr_no_valid", 32'(valid), 0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_bank_8x32_scan.md
# reg_bank_8x32_scan

Eight-entry, 32-bit register bank with a masked scan sequencer. It sits directly upstream of the 32-bit 8-to-1 mux: Out0..Out7 drive the mux data inputs In0..In7, and Select drives the mux Select. The sequencer steps Select through the entries enabled in a mask, one entry per Valid/Ready handshake, so the downstream consumer reads the selected word from the mux output.

## Interface
- WIDTH, 32, data width of each entry and of WrData/Out0..Out7. Entry count is fixed at 8, so Select is 3 bits.
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- WrEn  in  1  write strobe for the register bank.
- WrAddr  in  3  entry written when WrEn=1.
- WrData  in  WIDTH  write data.
- Start  in  1  scan request; sampled only in IDLE.
- Mask  in  8  entries to scan, bit i = entry i; sampled with Start.
- Ready  in  1  downstream has consumed the current entry.
- Out0..Out7  out  WIDTH each  registered entry contents, wired to mux In0..In7.
- Select  out  3  current entry index, wired to mux Select.
- Valid  out  1  Select names an entry to be consumed.
- Busy  out  1  scan in progress (SCAN or DONE).
- Done  out  1  one-cycle pulse at end of scan.

## Operation
- Reset state: all entries 0, Select 0, Valid 0, Busy 0, Done 0, state IDLE, latched mask 0.
- Write port:
  - Independent of the sequencer and active in every state.
  - When WrEn=1, entry WrAddr takes WrData at the edge; the new value appears on OutN the next cycle.
- States are IDLE, SCAN and DONE.
- IDLE:
  - Start=1 and Mask≠0: latch Mask, set Select to the lowest set bit, go to SCAN.
  - Start=1 and Mask=0: go to DONE with no Valid cycles.
  - Start=0: stay in IDLE.
- SCAN:
  - Valid=1 for the whole state.
  - Valid&Ready: Select moves to the next set bit of the latched mask strictly above the current Select. If there is none, go to DONE.
  - Ready=0: Select and Valid hold.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle, then IDLE.
- Start outside IDLE is ignored; it is neither queued nor restarts the scan.
- Select holds its last value whenever Valid=0, so the mux output stays stable.
- No wrap-around: indices are visited in strictly ascending order, each set bit exactly once.
- Mask changes after the Start edge have no effect on a scan in progress.
- Simultaneous write and handshake on the selected entry: the consumer sees the value held before the edge, and the new value is visible from the next cycle.
- Reset asserted mid-scan: the next cycle shows the full reset state, including all entries cleared, with no Done pulse.

## Timing
- Start accepted at edge N: Valid=1 and Busy=1 from cycle N+1.
- With Ready held at 1 and k set bits: Valid is high for k consecutive cycles and Done pulses in cycle N+k+1.
- Throughput is one entry per cycle; each cycle of Ready=0 adds one cycle.
- Start with Mask=0: Done pulses in cycle N+1; Valid never asserts.
- The earliest next Start is accepted at the edge ending the DONE cycle's successor (first IDLE cycle).
- All outputs are registered except Out0..Out7 fan-out, which comes directly from registers. There is no combinational path from any input to any output.

## Structure
- Shared package holds:
  - the state type (IDLE, SCAN, DONE);
  - NUM_ENTRIES=8 and SEL_WIDTH=3;
  - the default WIDTH=32.
- One sub-module, next_set_bit_8 (combinational):
  - Inputs: an 8-bit mask and a 3-bit current index, plus an include_current flag used for the first pick.
  - Outputs: the next index and a found flag.
- The top level holds the register array, the FSM, and the Select/Valid/Done registers.

## Test plan
- Reset then idle: Out0..Out7=0, Select=0, Valid=0, Busy=0, Done=0. Write entry 5 = 0xDEADBEEF, and Out5=0xDEADBEEF on the next cycle.
- Full scan: entries hold i*0x11111111, Mask=0xFF, Ready=1. Select=0..7 on consecutive cycles with Valid=1, and Done pulses exactly once in cycle 9 after Start.
- Sparse mask with backpressure: Mask=0x92 and Ready toggling 1,0,1,... Select visits 1, 4, 7 only, holding while Ready=0, and Done follows the final handshake by one cycle.
- Mask=0x00 start: Done pulses in cycle N+1, and Valid stays 0 throughout.
- Start during SCAN with a different mask: ignored; the original sequence completes unchanged.
- Write entry 3 (=0xA5A5A5A5) during the handshake on Select=3 with Mask=0x08: the consumer samples the old value, and Out3=0xA5A5A5A5 next cycle. Then assert Reset mid-scan: all state clears next cycle, with no Done pulse.
